// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
// Holds the bubble encoding, the PC increment, and the fetch FSM and IF/ID action enums.
package fetch_stage_pkg;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0033;  // add x0,x0,x0
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  // What the IF/ID register does on the next edge when not in reset.
  typedef enum logic [1:0] {
    IFID_HOLD    = 2'd0,
    IFID_BUBBLE  = 2'd1,
    IFID_CAPTURE = 2'd2
  } ifid_op_e;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program-counter register: synchronous active-low reset to RESET_PC, load enable, data in.
// The next-PC selection is done by the instantiating fetch stage.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // NOTE: reset is sampled on the clock edge (synchronous); state uses <= so all
  // registers see pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, instruction memory address and IF/ID register.
// Optional misaligned-redirect trap (RUN/FAULT FSM, misalign_fault port) under FETCH_MISALIGN_TRAP_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        in_fault;
  ifid_op_e    ifid_op;

  assign pc_plus4  = pc + PC_INCR;  // wraps modulo 2^32
  assign imem_addr = pc[31:2];

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_e state_q;
  fetch_state_e state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign in_fault       = (state_q == FETCH_FAULT);
  assign misalign_fault = in_fault;
`else
  logic unused_redirect_lsbs;

  // Low target bits are dropped when the trap is not built in.
  assign in_fault             = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    pc_next = pc_plus4;
    pc_load = 1'b1;
    ifid_op = IFID_CAPTURE;
`ifdef FETCH_MISALIGN_TRAP_EN
    state_d = state_q;
`endif
    if (in_fault) begin
      pc_load = 1'b0;
      ifid_op = IFID_BUBBLE;
    end else if (redirect) begin
      pc_next = {redirect_pc[31:2], 2'b00};
      ifid_op = IFID_BUBBLE;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = FETCH_FAULT;
      end
`endif
    end else if (stall) begin
      pc_load = 1'b0;
      ifid_op = IFID_HOLD;
    end
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (pc_next),
    .q     (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      case (ifid_op)
        IFID_CAPTURE: begin
          if_id_pc    <= pc;
          if_id_pc4   <= pc_plus4;
          if_id_instr <= imem_data;
          if_id_valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          if_id_pc    <= 32'h0;
          if_id_pc4   <= 32'h0;
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic checked every cycle against a reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc, if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid;
  logic        misalign_fault;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words at the bottom, a scrambled pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'd0) return 32'h0000_0083;
    if (a == 30'd1) return 32'h0040_2103;
    return {a[13:0], a[29:12]} ^ 32'hA5A5_0F0F;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .pc          (pc),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_fault (misalign_fault)
`endif
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign misalign_fault = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: architectural fetch state advanced once per rising edge.
  logic [31:0] m_pc, m_ifid_pc, m_ifid_pc4, m_ifid_instr;
  logic        m_valid, m_fault;
  bit          model_live = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = RESET_PC; m_ifid_pc = 0; m_ifid_pc4 = 0; m_ifid_instr = NOP;
      m_valid = 0; m_fault = 0; model_live = 1;
    end else if (model_live) begin
      if (m_fault) begin
        m_ifid_pc = 0; m_ifid_pc4 = 0; m_ifid_instr = NOP; m_valid = 0;
      end else if (redirect) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_ifid_pc = 0; m_ifid_pc4 = 0; m_ifid_instr = NOP; m_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        m_fault = (redirect_pc % 4) != 0;
`endif
      end else if (!stall) begin
        m_ifid_pc    = m_pc;
        m_ifid_pc4   = m_pc + 4;
        m_ifid_instr = mem_word(m_pc[31:2]);
        m_valid      = 1;
        m_pc         = m_pc + 4;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("pc",          pc,                   m_pc);
      check("imem_addr",   {2'b00, imem_addr},   {2'b00, m_pc[31:2]});
      check("if_id_pc",    if_id_pc,             m_ifid_pc);
      check("if_id_pc4",   if_id_pc4,            m_ifid_pc4);
      check("if_id_instr", if_id_instr,          m_ifid_instr);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      check("fault",       {31'b0, misalign_fault}, {31'b0, m_fault});
    end
  end

  // Advance one rising edge and settle; inputs are driven and literals checked here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    rst_n = r; stall = s; redirect = rd; redirect_pc = rpc;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    check("rst pc",    pc, RESET_PC);
    check("rst valid", {31'b0, if_id_valid}, 32'd0);
    check("rst instr", if_id_instr, NOP);

    // Sequential fetch from reset.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("seq0 pc",    if_id_pc, 32'h0);
    check("seq0 pc4",   if_id_pc4, 32'h4);
    check("seq0 instr", if_id_instr, 32'h0000_0083);
    check("seq0 valid", {31'b0, if_id_valid}, 32'd1);
    step();
    check("seq1 pc",    if_id_pc, 32'h4);
    check("seq1 pc4",   if_id_pc4, 32'h8);
    check("seq1 instr", if_id_instr, 32'h0040_2103);
    check("seq1 fpc",   pc, 32'h8);

    // Three-cycle stall at pc=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall pc",    pc, 32'h8);
      check("stall ifid",  if_id_pc, 32'h4);
    end
    stall = 1'b0;
    step();
    check("unstall ifid pc", if_id_pc, 32'h8);
    check("unstall instr",   if_id_instr, mem_word(30'd2));
    step();
    check("no dup ifid pc",  if_id_pc, 32'hC);

    // Redirect wins over a simultaneous stall.
    drive(1'b1, 1'b1, 1'b1, 32'h40);
    step();
    check("redir pc",    pc, 32'h40);
    check("redir valid", {31'b0, if_id_valid}, 32'd0);
    check("redir instr", if_id_instr, NOP);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("target ifid pc", if_id_pc, 32'h40);
    check("target valid",   {31'b0, if_id_valid}, 32'd1);

    // Wrap-around at the top of the address space.
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("wrap pc",      pc, 32'h0);
    check("wrap ifid pc4", if_id_pc4, 32'h0);
    check("wrap ifid pc", if_id_pc, 32'hFFFF_FFFC);

    // Misaligned redirect.
    drive(1'b1, 1'b0, 1'b1, 32'h22);
    step();
    check("misal pc", pc, 32'h20);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misal fault", {31'b0, misalign_fault}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      step();
      check("fault pc",    pc, 32'h20);
      check("fault valid", {31'b0, if_id_valid}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("fault clr",    {31'b0, misalign_fault}, 32'd0);
    check("fault rst pc", pc, RESET_PC);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
`else
    step();
    check("misal resume pc",    if_id_pc, 32'h20);
    check("misal resume valid", {31'b0, if_id_valid}, 32'd1);
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) rpc[31:12] = 20'h0;
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, rpc);
      step();
    end

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
